// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcode map and FSM state encoding.
package ctrl_pkg;

  localparam int unsigned OPC_ADD = 0;
  localparam int unsigned OPC_SUB = 1;
  localparam int unsigned OPC_AND = 2;
  localparam int unsigned OPC_OR  = 3;
  localparam int unsigned OPC_XOR = 4;
  localparam int unsigned OPC_NOT = 5;
  localparam int unsigned OPC_ASL = 6;
  localparam int unsigned OPC_ASR = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/ctrl_sequencer.sv
// Single-issue instruction sequencer: accept, execute for EXEC_CYCLES, write back.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int OPC_W = 3,
  parameter int EXEC_CYCLES = 1,
  parameter logic [2**OPC_W-1:0] OP_EN_MASK = '1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [OPC_W+2*REG_ADDR_W-1:0] instr,
  output logic [OPC_W-1:0]            alu_op,
  output logic [REG_ADDR_W-1:0]       dest_reg,
  output logic [REG_ADDR_W-1:0]       src_reg,
  output logic                        alu_start,
  output logic                        write_enable,
  output logic                        illegal_op,
  output logic                        busy,
  output logic [15:0]                 retired
);

  localparam int CNT_W = $clog2(EXEC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  state_t                state;
  logic [CNT_W-1:0]      exec_cnt;
  logic [OPC_W-1:0]      instr_opc;
  logic [REG_ADDR_W-1:0] instr_dest;
  logic [REG_ADDR_W-1:0] instr_src;

  assign instr_opc   = instr[OPC_W+2*REG_ADDR_W-1 -: OPC_W];
  assign instr_dest  = instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign instr_src   = instr[REG_ADDR_W-1:0];
  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Illegal opcodes pass through WB for one cycle without writing or retiring.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      exec_cnt     <= '0;
      alu_op       <= '0;
      dest_reg     <= '0;
      src_reg      <= '0;
      alu_start    <= 1'b0;
      write_enable <= 1'b0;
      illegal_op   <= 1'b0;
      retired      <= '0;
    end else begin
      alu_start    <= 1'b0;
      write_enable <= 1'b0;
      illegal_op   <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            alu_op   <= instr_opc;
            dest_reg <= instr_dest;
            src_reg  <= instr_src;
            exec_cnt <= '0;
            if (OP_EN_MASK[instr_opc]) begin
              alu_start <= 1'b1;
              state     <= EXEC;
            end else begin
              illegal_op <= 1'b1;
              state      <= WB;
            end
          end
        end
        EXEC: begin
          if (exec_cnt == CNT_LAST) begin
            write_enable <= 1'b1;
            retired      <= retired + 16'd1;
            state        <= WB;
          end else begin
            exec_cnt <= exec_cnt + 1'b1;
          end
        end
        WB: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 3, giving the register address width in bits (1..6).
REQ-002 The block SHALL have parameter OPC_W, default 3, giving the opcode width in bits (1..5).
REQ-003 The block SHALL have parameter EXEC_CYCLES, default 1, giving the ALU execute duration in cycles (1..15).
REQ-004 The block SHALL have parameter OP_EN_MASK, width 2**OPC_W, default all ones; bit k set means opcode k is legal.
REQ-005 Ports SHALL be, in order:
 clk  in  1  single clock; one clock; all state changes on rising edge
 rst  in  1  reset, synchronous, active-high
 instr_valid  in  1  instruction offered
 instr_ready  out  1  block accepts instruction this cycle
 instr  in  OPC_W+2*REG_ADDR_W  [top OPC_W]=opcode, [next REG_ADDR_W]=dest, [low REG_ADDR_W]=src
 alu_op  out  OPC_W  latched opcode
 dest_reg  out  REG_ADDR_W  latched destination address
 src_reg  out  REG_ADDR_W  latched source address
 alu_start  out  1  one-cycle pulse at start of execute
 write_enable  out  1  one-cycle register-file write strobe
 illegal_op  out  1  one-cycle pulse for masked opcode
 busy  out  1  high whenever state is not IDLE
 retired  out  16  count of legal instructions written back

Function
REQ-006 The FSM SHALL have states IDLE, EXEC, WB; instr_ready SHALL equal (state==IDLE).
REQ-007 Handshake: instruction accepted in cycle N iff instr_valid && instr_ready at edge N; instr SHALL be ignored otherwise.
REQ-008 On accept: opcode/dest/src SHALL be registered into alu_op/dest_reg/src_reg; state->EXEC; execute counter cleared.
REQ-009 alu_op, dest_reg, src_reg SHALL hold stable from cycle N+1 until the next accept.
REQ-010 Legal opcode: alu_start=1 in cycle N+1 only; EXEC SHALL last exactly EXEC_CYCLES cycles (N+1..N+EXEC_CYCLES); then WB in cycle N+EXEC_CYCLES+1.
REQ-011 In WB, write_enable=1 for exactly that cycle, retired increments by 1, state->IDLE; next accept earliest at edge N+EXEC_CYCLES+2.
REQ-012 Illegal opcode (OP_EN_MASK bit clear): illegal_op=1 in cycle N+1, no alu_start, no write_enable, retired unchanged, state N+1 = WB-skip directly back to IDLE in cycle N+2.
REQ-013 retired SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-014 instr_valid deasserting while busy SHALL have no effect; block SHALL never accept while busy.
REQ-015 All outputs SHALL be driven from registers (no combinational path instr -> outputs); instr_ready combinational from state only.

Reset
REQ-016 While rst=1 at an edge: state=IDLE, alu_op=0, dest_reg=0, src_reg=0, alu_start=0, write_enable=0, illegal_op=0, retired=0, execute counter=0.
REQ-017 rst asserted mid-EXEC or in WB SHALL abandon the instruction: no write_enable in the following cycle, retired not incremented; rst has priority over instr_valid.

Structure
REQ-018 Opcode localparams (ADD=0,SUB=1,AND=2,OR=3,XOR=4,NOT=5,ASL=6,ASR=7) and the FSM state enumeration SHALL live in shared package ctrl_pkg.
REQ-019 Execute counter width SHALL be $clog2(EXEC_CYCLES+1); no sub-module, single flat block.

Verification
REQ-020 Defaults, rst then instr=9'b001_010_011 valid at cycle 0 -> cycle1 alu_start=1, alu_op=1, dest=2, src=3; cycle2 write_enable=1; cycle3 ready=1, retired=1.
REQ-021 EXEC_CYCLES=4, instr=9'b110_111_000 -> alu_start cycle1, write_enable cycle5 only, ready low cycles1-5.
REQ-022 OP_EN_MASK=8'b0111_1111, opcode 7 -> illegal_op cycle1, write_enable never, retired unchanged, ready cycle2.
REQ-023 instr_valid held high 10 cycles with defaults -> exactly 4 accepts (cycles 0,3,6,9), retired=3 after cycle 9's WB pending.
REQ-024 rst pulsed in cycle 1 after accept at cycle 0 -> no write_enable cycle2, all outputs 0, retired=0.
REQ-025 retired preloaded by 65535 legal instructions, one more -> retired=0.
